// File: rtl/model_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : model_ctrl_if
// Brief   : Host-side input and output element streams of model_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface model_ctrl_if #(
    parameter int XB = 11,
    parameter int YB = 10
);
    logic          s_valid;
    logic          s_ready;
    logic [XB-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [YB-1:0] m_data;
    logic          m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface
`default_nettype wire

// File: rtl/model_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : model_ctrl
// Brief   : Frame sequencer: load x stream, pulse en, capture y, drain stream.
// Revision: 1.0 - initial release
// ============================================================================
module model_ctrl #(
    parameter int XD  = 64,
    parameter int XB  = 11,
    parameter int YD  = 16,
    parameter int YB  = 10,
    parameter int LAT = 1
) (
    input  wire logic                   clk,
    input  wire logic                   rstn,
    model_ctrl_if.slave                 io,
    output logic [XD-1:0][XB-1:0]       x_o,
    output logic                        en_o,
    input  wire logic [YD-1:0][YB-1:0]  y_i,
    output logic                        busy_o,
    output logic [15:0]                 frames_o
);

    localparam int XCW = (XD > 1) ? $clog2(XD) : 1;
    localparam int YCW = (YD > 1) ? $clog2(YD) : 1;
    localparam int WCW = $clog2(LAT + 1);

    localparam logic [XCW-1:0] X_LAST = XCW'(XD - 1);
    localparam logic [YCW-1:0] Y_LAST = YCW'(YD - 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(LAT);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FIRE  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                 state;
    logic [XCW-1:0]         xcnt;
    logic [YCW-1:0]         ycnt;
    logic [WCW-1:0]         wcnt;
    logic [YD-1:0][YB-1:0]  y_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_LOAD;
            xcnt     <= '0;
            ycnt     <= '0;
            wcnt     <= '0;
            x_o      <= '0;
            y_reg    <= '0;
            frames_o <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (io.s_valid) begin
                        x_o[xcnt] <= io.s_data;
                        if (xcnt == X_LAST) begin
                            xcnt  <= '0;
                            state <= S_FIRE;
                        end else begin
                            xcnt <= xcnt + 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    wcnt  <= WCW'(1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // y_i is only trusted on the last wait cycle
                    if (wcnt == W_LAST) begin
                        y_reg <= y_i;
                        ycnt  <= '0;
                        state <= S_DRAIN;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (io.m_ready) begin
                        if (ycnt == Y_LAST) begin
                            ycnt     <= '0;
                            frames_o <= frames_o + 16'd1;
                            state    <= S_LOAD;
                        end else begin
                            ycnt <= ycnt + 1'b1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Outputs depend only on registered state so no input reaches an output.
    assign io.s_ready = (state == S_LOAD);
    assign en_o       = (state == S_FIRE);
    assign busy_o     = (state != S_LOAD);
    assign io.m_valid = (state == S_DRAIN);
    assign io.m_data  = (state == S_DRAIN) ? y_reg[ycnt] : '0;
    assign io.m_last  = (state == S_DRAIN) && (ycnt == Y_LAST);

endmodule
`default_nettype wire

// File: tb/tb_model_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_model_ctrl
// Brief   : Scoreboard bench for model_ctrl with a latency-LAT stub of model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_model_ctrl;
    localparam int XD  = 64;
    localparam int XB  = 11;
    localparam int YD  = 16;
    localparam int YB  = 10;
    localparam int LAT = 4;

    logic                   clk  = 1'b0;
    logic                   rstn = 1'b1;
    logic [XD-1:0][XB-1:0]  x_o;
    logic                   en_o;
    logic [YD-1:0][YB-1:0]  y_i;
    logic                   busy_o;
    logic [15:0]            frames_o;

    model_ctrl_if #(.XB(XB), .YB(YB)) sif ();

    model_ctrl #(.XD(XD), .XB(XB), .YD(YD), .YB(YB), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn), .io(sif), .x_o(x_o), .en_o(en_o),
        .y_i(y_i), .busy_o(busy_o), .frames_o(frames_o)
    );

    always #5 clk = ~clk;

    // Stub datapath: y[k] = x[k] + x[k+16], valid only LAT cycles after en.
    int                     stub_cnt = 0;
    logic [XD-1:0][XB-1:0]  stub_x = '0;
    logic [YD-1:0][YB-1:0]  garb = '0;

    function automatic logic [YB-1:0] stub_f(input logic [XB-1:0] a, input logic [XB-1:0] b);
        logic [XB:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[YB-1:0];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < YD; k++) garb[k] <= YB'($urandom);
        if (en_o) begin
            stub_cnt <= 1;
            stub_x   <= x_o;
        end else if (stub_cnt != 0 && stub_cnt <= LAT) begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    always_comb begin
        y_i = garb;
        if (stub_cnt == LAT)
            for (int k = 0; k < YD; k++) y_i[k] = stub_f(stub_x[k], stub_x[k+16]);
    end

    typedef struct packed { logic [YB-1:0] d; logic l; } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int hs_n  = 0;
    int en_cnt = 0;
    int out_idx = 0;
    int mr_rate = 100;
    bit first_seen = 1'b1;
    bit busy_exp   = 1'b0;
    bit chk_frames = 1'b0;
    bit hold_valid = 1'b0;
    logic [YB-1:0] hold_data = '0;
    logic          hold_last = 1'b0;
    logic [15:0]   exp_frames = '0;
    logic [XD-1:0][XB-1:0] xsnap = '0;
    logic [XB-1:0] fbuf [XD];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, 32'(sif.s_ready), 32'd1);
        chk({tag, "_m_valid"}, 32'(sif.m_valid), 32'd0);
        chk({tag, "_m_last"},  32'(sif.m_last),  32'd0);
        chk({tag, "_m_data"},  32'(sif.m_data),  32'd0);
        chk({tag, "_en"},      32'(en_o),        32'd0);
        chk({tag, "_busy"},    32'(busy_o),      32'd0);
        chk({tag, "_frames"},  32'(frames_o),    32'd0);
        total++;
        if (x_o !== '0) begin
            bad++;
            $display("FAIL %s_x_o: x_o not cleared", tag);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < XD; i++) fbuf[i] = XB'($urandom);
    endtask

    task automatic send_frame(input int vrate);
        logic [XD-1:0][XB-1:0] xv;
        exp_t e;
        for (int k = 0; k < YD; k++) begin
            e.d = YB'((int'(fbuf[k]) + int'(fbuf[k+16])) % (1 << YB));
            e.l = (k == YD - 1);
            sb.push_back(e);
        end
        for (int i = 0; i < XD; i++) xv[i] = fbuf[i];
        for (int i = 0; i < XD; i++) begin
            bit done = 1'b0;
            bit hs;
            int g = 0;
            while (!done) begin
                @(negedge clk);
                if (int'($urandom_range(99)) < vrate) begin
                    sif.s_valid = 1'b1;
                    sif.s_data  = fbuf[i];
                    hs = sif.s_ready;
                end else begin
                    sif.s_valid = 1'b0;
                    hs = 1'b0;
                end
                @(posedge clk);
                if (hs) done = 1'b1;
                g++;
                if (!done && g > 5000) begin
                    total++; bad++;
                    $display("FAIL send_timeout: element %0d never accepted", i);
                    done = 1'b1;
                end
            end
        end
        hs_n       = ncyc;
        en_cnt     = 0;
        first_seen = 1'b0;
        busy_exp   = 1'b1;
        xsnap      = xv;
        #1 sif.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy_exp || sb.size() != 0) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (busy_exp || sb.size() != 0) begin
            bad++;
            $display("FAIL idle_timeout: busy_exp=%0d pending=%0d", busy_exp, sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        sif.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 sif.m_ready = (int'($urandom_range(99)) < mr_rate);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (rstn) begin
            chk("busy", 32'(busy_o), 32'(busy_exp));
            chk("s_ready", 32'(sif.s_ready), 32'(!busy_exp));
            if (en_o) begin
                en_cnt++;
                chk("en_timing", 32'(ncyc), 32'(hs_n + 1));
            end
            if (chk_frames) begin
                chk("frames", 32'(frames_o), 32'(exp_frames));
                chk_frames = 1'b0;
            end
            if (hold_valid) begin
                chk("hold_valid", 32'(sif.m_valid), 32'd1);
                chk("hold_data", 32'(sif.m_data), 32'(hold_data));
                chk("hold_last", 32'(sif.m_last), 32'(hold_last));
                hold_valid = 1'b0;
            end
            if (sif.m_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    chk("latency", 32'(ncyc - hs_n), 32'(LAT + 2));
                    chk("en_pulses", 32'(en_cnt), 32'd1);
                    total++;
                    if (x_o !== xsnap) begin
                        bad++;
                        $display("FAIL x_assembly: x_o differs from streamed frame");
                    end
                end
                if (sif.m_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL spurious_beat: got data %0h with nothing expected", sif.m_data);
                    end else begin
                        e = sb.pop_front();
                        if (sif.m_data !== e.d || sif.m_last !== e.l) begin
                            bad++;
                            $display("FAIL out_beat: got data %0h last %0d expected data %0h last %0d",
                                     sif.m_data, sif.m_last, e.d, e.l);
                        end
                        if (e.l) begin
                            exp_frames = exp_frames + 16'd1;
                            chk_frames = 1'b1;
                            busy_exp   = 1'b0;
                        end
                    end
                    out_idx++;
                end else begin
                    hold_valid = 1'b1;
                    hold_data  = sif.m_data;
                    hold_last  = sif.m_last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        #3 rstn = 1'b0;
        #1 check_reset("rst");
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Ramp data, no stalls: outputs 16,18,...,46
        for (int i = 0; i < XD; i++) fbuf[i] = XB'(i);
        send_frame(100);
        wait_idle();
        chk("frames_after_1", 32'(frames_o), 32'd1);

        // Input gaps and output backpressure
        mr_rate = 30;
        for (int i = 0; i < XD; i++) fbuf[i] = XB'(i);
        send_frame(50);
        wait_idle();
        rand_frame();
        send_frame(50);
        wait_idle();

        // Reset during DRAIN after five output beats
        rand_frame();
        out_idx = 0;
        send_frame(60);
        g = 0;
        while (out_idx < 5 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        chk("midrst_reached", 32'(out_idx >= 5), 32'd1);
        #2 rstn = 1'b0;
        sb.delete();
        busy_exp   = 1'b0;
        hold_valid = 1'b0;
        chk_frames = 1'b0;
        exp_frames = '0;
        en_cnt     = 0;
        first_seen = 1'b1;
        #1 check_reset("midrst");
        sif.s_valid = 1'b1;
        sif.s_data  = '1;
        repeat (2) @(negedge clk);
        check_reset("inrst");
        rstn = 1'b1;
        sif.s_valid = 1'b0;
        repeat (5) @(negedge clk);
        rand_frame();
        send_frame(70);
        wait_idle();
        chk("frames_after_rst", 32'(frames_o), 32'd1);

        // Back-to-back frames, then wrap of the frame counter
        mr_rate = 100;
        rand_frame();
        send_frame(100);
        rand_frame();
        send_frame(100);
        wait_idle();
        chk("frames_b2b", 32'(frames_o), 32'd3);
        @(posedge clk);
        #2 force dut.frames_o = 16'hFFFF;
        exp_frames = 16'hFFFF;
        #1 release dut.frames_o;
        mr_rate = 80;
        rand_frame();
        send_frame(80);
        wait_idle();
        chk("frames_wrap", 32'(frames_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/model_ctrl.md
# model_ctrl

Frame sequencer for the `model` inference datapath. It accepts an input frame as a valid/ready stream of XD elements and assembles the parallel `x` vector. It then pulses `en` for exactly one cycle and waits the datapath's fixed latency, capturing the parallel `y` vector into an output register. Finally it streams the YD result elements out over a valid/ready interface with a last flag. It sits between the host-side streaming fabric and `model`, and is the only driver of `model.x` and `model.en`.

## Interface
- XD, 64: input elements per frame.
- XB, 11: bits per input element.
- YD, 16: output elements per frame.
- YB, 10: bits per output element.
- LAT, 1: cycles from the `en` cycle until `y_i` is valid. Legal range is LAT ≥ 1.

- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  controller accepts an input element.
- s_data  in  XB  input element; element 0 comes first.
- x_o  out  XD×XB  packed `[XD-1:0][XB-1:0]` vector to `model.x`.
- en_o  out  1  one-cycle start pulse to `model.en`.
- y_i  in  YD×YB  packed `[YD-1:0][YB-1:0]` vector from `model.y`.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accepts the output element.
- m_data  out  YB  output element; element 0 comes first.
- m_last  out  1  marks element YD-1.
- busy_o  out  1  high in FIRE, WAIT and DRAIN.
- frames_o  out  16  count of completed frames; wraps modulo 2^16.

## Operation
The controller has four states: LOAD, FIRE, WAIT and DRAIN. Reset state is LOAD.

- **LOAD**
  - s_ready=1.
  - On each s_valid&&s_ready: x_o[xcnt] ← s_data, then xcnt++.
  - When the accepted beat has xcnt==XD-1: xcnt ← 0, go to FIRE.
- **FIRE** (exactly 1 cycle)
  - en_o=1, s_ready=0.
  - wcnt ← 1, go to WAIT.
- **WAIT** (exactly LAT cycles)
  - en_o=0.
  - If wcnt==LAT: y_reg ← y_i, ycnt ← 0, go to DRAIN.
  - Otherwise: wcnt++.
- **DRAIN**
  - m_valid=1, m_data=y_reg[ycnt], m_last=(ycnt==YD-1).
  - On each m_valid&&m_ready: ycnt++.
  - On the last element: frames_o++, go to LOAD.

Datapath and output rules:
- x_o holds its value through FIRE, WAIT and DRAIN, and is only overwritten by new LOAD beats.
- `model` sees a stable x for the whole computation.
- y_reg is a YD×YB register; y_i is not sampled in any other cycle.
- m_data, m_last, s_ready, m_valid, en_o and busy_o are decoded from registered state, index and y_reg/x_o only. There is no combinational path from s_valid or m_ready to any output.
- Counter widths:
  - xcnt is $clog2(XD).
  - ycnt is $clog2(YD).
  - wcnt is $clog2(LAT+1).
- Counters never exceed their terminal values.

## Timing
- Reset (rstn low, asynchronous):
  - state=LOAD; xcnt, ycnt, wcnt=0.
  - x_o=0, y_reg=0, frames_o=0.
  - en_o=0, m_valid=0, m_last=0, m_data=0, busy_o=0.
  - s_ready reads 1, because it is decoded from LOAD. Beats presented while rstn is low are not captured.
- Reset mid-frame, in any state: the partial frame is discarded with no en_o pulse and no output beats. Operation restarts at element 0 of a new frame.
- Input side:
  - Throughput is one element per cycle when s_valid is held high.
  - The last input beat accepted at edge N gives en_o=1 in cycle N+1 (the FIRE cycle).
- Capture and output:
  - y_i is captured at the edge ending the LAT-th WAIT cycle.
  - The first m_valid appears in the following cycle.
  - Minimum frame latency, from the last input handshake to the first m_valid, is LAT+2 cycles (FIRE, LAT WAIT cycles, then DRAIN).
- Backpressure:
  - With m_ready low, m_valid, m_data and m_last stay stable until the handshake.
  - An s_valid gap in LOAD simply stalls xcnt.
- Back-to-back frames:
  - s_ready returns to 1 in the cycle after the m_last handshake.
  - Input and output are not overlapped; s_ready=0 throughout FIRE, WAIT and DRAIN.
- frames_o increments on the same edge as the m_last handshake. It wraps from 0xFFFF to 0x0000.

## Test plan
1. **Basic frame.** LAT=1 with a stub model that registers y[k]=x[k]+x[k+16] on en. Stream x[i]=i with continuous valid.
   - en_o is high for exactly 1 cycle, one cycle after beat 63.
   - First m_valid arrives 3 cycles after the last input handshake.
   - m_data sequence is 16,18,…,46; m_last only on element 15; frames_o=1.
2. **Latency parameter.** LAT=4 with a stub whose y becomes valid only 4 cycles after en (garbage before that).
   - Captured values are correct.
   - First m_valid arrives 6 cycles after the last input handshake.
3. **Backpressure and gaps.** Randomise s_valid at 50% and m_ready at 30%.
   - All 64 inputs land in x_o in order.
   - The output sequence matches test 1.
   - m_data and m_last are stable while m_valid&&!m_ready.
4. **Reset mid-operation.** Assert rstn low during DRAIN after 5 output beats, then release and send a new frame.
   - All outputs return to reset values immediately.
   - No remaining beats from the old frame are emitted.
   - The new frame's results are correct; frames_o=1.
5. **Back-to-back frames with wrap.** Run 3 consecutive frames with distinct data, and force frames_o=0xFFFF before the last one.
   - s_ready is low from FIRE through the last DRAIN handshake.
   - Each frame's outputs are correct.
   - frames_o reads 0x0000 after the third frame.
